// File: rtl/hazard_stall_unit.sv
// Load-use stall, taken-branch flush and memory-busy freeze controller for the LEGv8 ID stage.
// A watchdog latches o_mem_timeout when data memory stays busy too long; only reset clears it.
module hazard_stall_unit #(
    parameter int CNT_W    = 16,
    parameter int MAX_WAIT = 15
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic [4:0]       i_rn_id,
    input  logic [4:0]       i_rm_id,
    input  logic [4:0]       i_rd_id,
    input  logic             i_uses_rn_id,
    input  logic             i_uses_rm_id,
    input  logic             i_reads_rd_id,
    input  logic             i_mem_read_ex,
    input  logic [4:0]       i_rd_ex,
    input  logic             i_branch_taken_id,
    input  logic             i_mem_busy_mem,
    output logic             o_pc_write,
    output logic             o_ifid_write,
    output logic             o_bubble_id,
    output logic             o_flush_if,
    output logic             o_freeze,
    output logic             o_mem_timeout,
    output logic [CNT_W-1:0] o_stall_count,
    output logic [1:0]       o_dbg_state
);

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_WAIT_MEM = 2'd1,
        ST_HUNG     = 2'd2
    } state_t;

    localparam logic [7:0] MAX_WAIT_C = 8'(MAX_WAIT);

    state_t           r_state;
    state_t           w_state_next;
    logic [7:0]       r_wait_cnt;
    logic [7:0]       w_wait_cnt_next;
    logic             r_mem_timeout;
    logic             w_mem_timeout_next;
    logic [CNT_W-1:0] r_stall_count;
    logic             w_load_use;

    // X31 is XZR: a load targeting it never produces a value anyone waits on.
    assign w_load_use = i_mem_read_ex && (i_rd_ex != 5'd31) &&
                        ((i_uses_rn_id  && (i_rn_id == i_rd_ex)) ||
                         (i_uses_rm_id  && (i_rm_id == i_rd_ex)) ||
                         (i_reads_rd_id && (i_rd_id == i_rd_ex)));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state       <= ST_RUN;
            r_wait_cnt    <= 8'd0;
            r_mem_timeout <= 1'b0;
            r_stall_count <= '0;
        end else begin
            r_state       <= w_state_next;
            r_wait_cnt    <= w_wait_cnt_next;
            r_mem_timeout <= w_mem_timeout_next;
            if (!o_pc_write && (r_stall_count != {CNT_W{1'b1}}))
                r_stall_count <= r_stall_count + CNT_W'(1);
        end
    end

    always_comb begin
        o_pc_write         = 1'b1;
        o_ifid_write       = 1'b1;
        o_bubble_id        = 1'b0;
        o_flush_if         = 1'b0;
        o_freeze           = 1'b0;
        w_state_next       = r_state;
        w_wait_cnt_next    = r_wait_cnt;
        w_mem_timeout_next = r_mem_timeout;

        if (i_reset) begin
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            o_bubble_id  = 1'b1;
            o_flush_if   = 1'b1;
        end else if (r_state == ST_HUNG) begin
            o_freeze     = 1'b1;
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
        end else if (i_mem_busy_mem) begin
            // ID holds while frozen, so any pending hazard or branch is re-seen on release.
            o_freeze     = 1'b1;
            o_pc_write   = 1'b0;
            o_ifid_write = 1'b0;
            if (r_state == ST_RUN) begin
                w_state_next    = ST_WAIT_MEM;
                w_wait_cnt_next = 8'd1;
            end else if (r_wait_cnt == MAX_WAIT_C) begin
                w_state_next       = ST_HUNG;
                w_mem_timeout_next = 1'b1;
            end else begin
                w_wait_cnt_next = r_wait_cnt + 8'd1;
            end
        end else begin
            if (r_state == ST_WAIT_MEM) begin
                w_state_next    = ST_RUN;
                w_wait_cnt_next = 8'd0;
            end
            // A stall beats a taken branch; the branch re-resolves next cycle.
            if (w_load_use) begin
                o_pc_write   = 1'b0;
                o_ifid_write = 1'b0;
                o_bubble_id  = 1'b1;
            end else if (i_branch_taken_id) begin
                o_flush_if = 1'b1;
            end
        end
    end

    assign o_mem_timeout = r_mem_timeout;
    assign o_stall_count = r_stall_count;
    assign o_dbg_state   = r_state;

endmodule
